// File: rtl/taxi_meter_ctrl.sv
// Trip sequencer for the taxi meter: turns start/pause/stop key pulses and wheel-encoder
// activity into launch/step controls, the trip-start clear pulse and the pause-time count.
module taxi_meter_ctrl #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int IDLE_TIMEOUT_S = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic        key_stop,
  input  logic        encoder_pulses,
  output logic        flag_key_launch,
  output logic        flag_key_step,
  output logic        meter_clr,
  output logic [1:0]  meter_state,
  output logic [15:0] wait_sec,
  output logic        auto_paused
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_SETTLE = 2'b11
  } state_t;

  state_t          state, state_next;
  logic            enc_s1, enc_s2, enc_d, enc_edge;
  logic [PW-1:0]   presc;
  logic [7:0]      idle_cnt;
  logic            tick, timeout, clr_trip, auto_next, state_change;

  assign meter_state = state;

  // Registered edge strobe: raw rise -> enc_edge three sys_clk edges later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enc_s1   <= 1'b0;
      enc_s2   <= 1'b0;
      enc_d    <= 1'b0;
      enc_edge <= 1'b0;
    end else begin
      enc_s1   <= encoder_pulses;
      enc_s2   <= enc_s1;
      enc_d    <= enc_s2;
      enc_edge <= enc_s2 & ~enc_d;
    end
  end

  assign tick = (presc == PW'(CLK_FREQ - 1));

  // Fires on the tick that would bring the idle timer up to the timeout.
  assign timeout = (state == ST_RUN) && tick && !enc_edge &&
                   (({1'b0, idle_cnt} + 9'd1) == 9'(IDLE_TIMEOUT_S));

  always_comb begin
    state_next = state;
    clr_trip   = 1'b0;
    auto_next  = auto_paused;
    case (state)
      ST_IDLE: begin
        if (key_start) begin
          state_next = ST_RUN;
          clr_trip   = 1'b1;
        end
      end
      ST_RUN: begin
        if (key_stop) begin
          state_next = ST_SETTLE;
        end else if (key_pause) begin
          state_next = ST_PAUSE;
          auto_next  = 1'b0;
        end else if (timeout) begin
          state_next = ST_PAUSE;
          auto_next  = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (key_stop) begin
          state_next = ST_SETTLE;
        end else if (key_pause) begin
          state_next = ST_RUN;
        end else if (enc_edge && auto_paused) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        if (key_stop) begin
          state_next = ST_IDLE;
        end else if (key_start) begin
          state_next = ST_RUN;
          clr_trip   = 1'b1;
        end
      end
    endcase
    if (state == ST_PAUSE && state_next != ST_PAUSE) auto_next = 1'b0;
    if (clr_trip) auto_next = 1'b0;
  end

  assign state_change = (state_next != state);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      flag_key_launch <= 1'b0;
      flag_key_step   <= 1'b0;
      meter_clr       <= 1'b0;
      auto_paused     <= 1'b0;
    end else begin
      state           <= state_next;
      flag_key_launch <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      flag_key_step   <= (state_next == ST_PAUSE) || (state_next == ST_SETTLE);
      meter_clr       <= clr_trip;
      auto_paused     <= auto_next;
    end
  end

  // Prescaler and idle timer restart on every state change so timing is relative to entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc    <= '0;
      idle_cnt <= '0;
    end else begin
      if (state_change || (state == ST_RUN && enc_edge) || tick) presc <= '0;
      else presc <= presc + PW'(1);

      if (state_change || enc_edge) idle_cnt <= '0;
      else if (state == ST_RUN && tick) idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_sec <= '0;
    end else if (clr_trip) begin
      wait_sec <= '0;
    end else if (state == ST_PAUSE && tick && wait_sec != 16'hFFFF) begin
      wait_sec <= wait_sec + 16'd1;
    end
  end

endmodule

// File: tb/tb_taxi_meter_ctrl.sv
// Directed bench for taxi_meter_ctrl: main instance at CLK_FREQ=10/TIMEOUT=3, plus a
// CLK_FREQ=1 instance so wait_sec saturation is reachable in a short run.
`timescale 1ns/1ps
module tb_taxi_meter_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        key_start = 1'b0, key_pause = 1'b0, key_stop = 1'b0, encoder_pulses = 1'b0;
  logic        flag_key_launch, flag_key_step, meter_clr, auto_paused;
  logic [1:0]  meter_state;
  logic [15:0] wait_sec;

  logic        sat_start = 1'b0, sat_pause = 1'b0;
  logic        sat_launch, sat_step, sat_clr, sat_auto;
  logic [1:0]  sat_state;
  logic [15:0] sat_wait;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  taxi_meter_ctrl #(.CLK_FREQ(10), .IDLE_TIMEOUT_S(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .key_start(key_start), .key_pause(key_pause), .key_stop(key_stop),
    .encoder_pulses(encoder_pulses),
    .flag_key_launch(flag_key_launch), .flag_key_step(flag_key_step),
    .meter_clr(meter_clr), .meter_state(meter_state),
    .wait_sec(wait_sec), .auto_paused(auto_paused)
  );

  taxi_meter_ctrl #(.CLK_FREQ(1), .IDLE_TIMEOUT_S(3)) u_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .key_start(sat_start), .key_pause(sat_pause), .key_stop(1'b0),
    .encoder_pulses(1'b0),
    .flag_key_launch(sat_launch), .flag_key_step(sat_step),
    .meter_clr(sat_clr), .meter_state(sat_state),
    .wait_sec(sat_wait), .auto_paused(sat_auto)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called at a negedge; returns one negedge later, after the edge that acts on the keys.
  task automatic pulse(input logic s, input logic p, input logic t);
    key_start = s;
    key_pause = p;
    key_stop  = t;
    @(negedge sys_clk);
    key_start = 1'b0;
    key_pause = 1'b0;
    key_stop  = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic la,
                           input logic sp, input logic [15:0] ws, input logic ap);
    check({tag, ".state"},  meter_state,     st);
    check({tag, ".launch"}, flag_key_launch, la);
    check({tag, ".step"},   flag_key_step,   sp);
    check({tag, ".wait"},   wait_sec,        ws);
    check({tag, ".auto"},   auto_paused,     ap);
  endtask

  initial begin
    cycles(3);
    sys_rst_n = 1'b1;
    check_all("reset", 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    check("reset.clr", meter_clr, 1'b0);
    cycles(2);

    // Trip start
    pulse(1'b1, 1'b0, 1'b0);
    check_all("start", 2'b01, 1'b1, 1'b0, 16'd0, 1'b0);
    check("start.clr", meter_clr, 1'b1);
    cycles(1);
    check("start.clr_off", meter_clr, 1'b0);

    // Manual pause; an encoder edge must not resume
    pulse(1'b0, 1'b1, 1'b0);
    check_all("mpause", 2'b10, 1'b1, 1'b1, 16'd0, 1'b0);
    cycles(31);
    encoder_pulses = 1'b1;
    cycles(3);
    encoder_pulses = 1'b0;
    cycles(1);
    check_all("mpause35", 2'b10, 1'b1, 1'b1, 16'd3, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_all("mresume", 2'b01, 1'b1, 1'b0, 16'd3, 1'b0);

    // Auto pause after 30 quiet cycles, encoder resume 4 cycles after the raw edge
    cycles(29);
    check("apause29.state", meter_state, 2'b01);
    cycles(1);
    check_all("apause30", 2'b10, 1'b1, 1'b1, 16'd3, 1'b1);
    encoder_pulses = 1'b1;
    cycles(3);
    check("eres3.state", meter_state, 2'b10);
    encoder_pulses = 1'b0;
    cycles(1);
    check_all("eres4", 2'b01, 1'b1, 1'b0, 16'd3, 1'b0);

    // Simultaneous pause+stop -> SETTLE, then restart and double stop
    pulse(1'b0, 1'b1, 1'b1);
    check_all("settle", 2'b11, 1'b0, 1'b1, 16'd3, 1'b0);
    cycles(12);
    check("settle.frozen", wait_sec, 16'd3);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("restart", 2'b01, 1'b1, 1'b0, 16'd0, 1'b0);
    check("restart.clr", meter_clr, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("stop1.state", meter_state, 2'b11);
    pulse(1'b0, 1'b0, 1'b1);
    check_all("stop2", 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);

    // Reset mid-PAUSE with wait_sec=4
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    cycles(45);
    check("prerst.wait", wait_sec, 16'd4);
    #2 sys_rst_n = 1'b0;
    #1;
    check_all("asyncrst", 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    check("asyncrst.clr", meter_clr, 1'b0);
    cycles(2);
    sys_rst_n = 1'b1;
    cycles(1);
    check_all("postrst", 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    check("postrst.clr", meter_clr, 1'b0);

    // Saturation on the one-cycle-tick instance
    sat_start = 1'b1;
    cycles(1);
    sat_start = 1'b0;
    sat_pause = 1'b1;
    cycles(1);
    sat_pause = 1'b0;
    check("sat.state", sat_state, 2'b10);
    cycles(65534);
    check("sat.fffe", sat_wait, 16'hFFFE);
    cycles(3);
    check("sat.ffff", sat_wait, 16'hFFFF);
    cycles(2);
    check("sat.hold", sat_wait, 16'hFFFF);
    check("sat.state2", sat_state, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/taxi_meter_ctrl.md
# taxi_meter_ctrl

Trip sequencer for the taxi meter. It turns the debounced start/pause/stop key pulses and the wheel-encoder activity into the `flag_key_launch` and `flag_key_step` controls consumed by the distance counter. It clears the meter at the start of each trip and accumulates waiting time in seconds while the cab is paused. It sits between the key-filter blocks and the distance/fare datapath, clocked on `sys_clk`.

## Interface
- `CLK_FREQ`, default 50_000_000: sys_clk cycles per second (1 s tick period).
- `IDLE_TIMEOUT_S`, default 5: whole seconds without an encoder edge in RUN before automatic pause; range 1..255.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `key_start`  in  1  single-cycle pulse, sys_clk-synchronous (debounced start key).
- `key_pause`  in  1  single-cycle pulse, sys_clk-synchronous (pause/resume key).
- `key_stop`  in  1  single-cycle pulse, sys_clk-synchronous (end trip / return to idle).
- `encoder_pulses`  in  1  raw wheel encoder, asynchronous; high and low phases each ≥ 3 sys_clk.
- `flag_key_launch`  out  1  trip active; to distance counter.
- `flag_key_step`  out  1  counting suspended; to distance counter.
- `meter_clr`  out  1  one-cycle pulse; clears distance/fare datapath at trip start.
- `meter_state`  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 SETTLE.
- `wait_sec`  out  16  accumulated pause seconds for current trip, saturating.
- `auto_paused`  out  1  1 when PAUSE was entered by timeout, not by key.

## Operation
- Encoder path: 2-flop synchronizer, then a third register for rising-edge detect. `enc_edge` is a 1-cycle strobe.
- Prescaler: counts 0..CLK_FREQ-1; `tick` is asserted when the count equals CLK_FREQ-1, and the prescaler wraps to 0. The prescaler is forced to 0 on every state transition and on each `enc_edge` while in RUN.
- Idle timer (8-bit):
  - Increments on `tick` in RUN.
  - Cleared on `enc_edge` and on any state transition.
  - Reaching IDLE_TIMEOUT_S triggers the auto pause.
- FSM (transitions evaluated each cycle):
  - IDLE: `key_start` → RUN. Asserts `meter_clr` and clears `wait_sec` and `auto_paused`.
  - RUN:
    - `key_stop` → SETTLE.
    - Else `key_pause` → PAUSE, `auto_paused`=0.
    - Else idle timer == IDLE_TIMEOUT_S → PAUSE, `auto_paused`=1.
  - PAUSE:
    - `key_stop` → SETTLE.
    - Else `key_pause` → RUN.
    - Else `enc_edge` with `auto_paused`=1 → RUN.
    - `enc_edge` with `auto_paused`=0 is ignored.
    - `wait_sec` += 1 on `tick`, saturating at 0xFFFF.
  - SETTLE:
    - `key_stop` → IDLE.
    - Else `key_start` → RUN, with `meter_clr` and clearing as from IDLE.
    - `wait_sec` holds.
- Simultaneous events, priority: `key_stop` > `key_pause` > `key_start` > `enc_edge`/timeout. Keys not listed for the current state are ignored.
- Flags (registered, decoded from the next state):
  - IDLE: launch=0, step=0.
  - RUN: launch=1, step=0.
  - PAUSE: launch=1, step=1.
  - SETTLE: launch=0, step=1.
- `auto_paused` is cleared on any exit from PAUSE.

## Timing
- Reset values: `meter_state`=IDLE, `flag_key_launch`=0, `flag_key_step`=0, `meter_clr`=0, `wait_sec`=0, `auto_paused`=0. The synchronizer, prescaler and idle timer are also 0.
- Reset may assert at any time, including mid-trip: all outputs return to reset values asynchronously, and no `meter_clr` is issued.
- Key pulse in cycle N → `meter_state` and flags updated at edge N+1. `meter_clr` is high exactly during cycle N+1.
- Encoder rising edge → `enc_edge` 3 sys_clk later (2 sync + 1 detect). Encoder-driven resume therefore updates the flags 4 cycles after the raw edge.
- Auto pause: the last `enc_edge` at cycle E → PAUSE at E + IDLE_TIMEOUT_S·CLK_FREQ + 1.
- First `wait_sec` increment: CLK_FREQ cycles after entering PAUSE.
- Re-entering PAUSE within a trip continues accumulating `wait_sec`.

## Test plan
Bench parameters: CLK_FREQ=10, IDLE_TIMEOUT_S=3.

- **Reset mid-PAUSE:** drop `sys_rst_n` with `wait_sec`=4 → all outputs 0 immediately; state 00 after release.
- **Trip start:** `key_start` at cycle 5 → cycle 6: state=01, launch=1, step=0, `meter_clr`=1 for 1 cycle, `wait_sec`=0.
- **Manual pause:** in RUN, `key_pause` → state=10, step=1. Hold 35 cycles → `wait_sec`=3. Encoder edges do not resume. `key_pause` → RUN, `wait_sec` stays 3.
- **Auto pause/resume:** in RUN with no encoder activity for 30 cycles after the last edge → state=10, `auto_paused`=1. Encoder rising edge → RUN 4 cycles later, `auto_paused`=0.
- **Simultaneous keys and settle:** `key_pause` and `key_stop` in the same RUN cycle → SETTLE (launch=0, step=1, `wait_sec` frozen). `key_start` → RUN with `meter_clr` and `wait_sec`=0. `key_stop` twice → IDLE.
- **Saturation:** force `wait_sec` to 0xFFFE in PAUSE, run 3 ticks → `wait_sec`=0xFFFF and holds.
